// File: rtl/b_lut_opfetch.sv
// Operand fetch for xc.lut: reads rs1/rs2, then rs3, over a
// two-port register file and holds the three operands for the LUT stage.
module b_lut_opfetch #(
    parameter bit X0_ZERO = 1'b1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rs3,
    input  logic [4:0]  req_rd,
    output logic [4:0]  rf_ra_addr,
    output logic [4:0]  rf_rb_addr,
    input  logic [31:0] rf_ra_data,
    input  logic [31:0] rf_rb_data,
    output logic [31:0] lut_crs1,
    output logic [31:0] lut_crs2,
    output logic [31:0] lut_crs3,
    output logic [4:0]  lut_rd,
    output logic        lut_valid,
    input  logic        lut_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH2 = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        accept;
    logic [31:0] crs1_q, crs2_q, crs3_q;
    logic [4:0]  rs3_q, rd_q;

    // Register x0 reads as zero when X0_ZERO is set.
    function automatic logic [31:0] op_sel(input logic [4:0] a,
                                           input logic [31:0] d);
        return (X0_ZERO && a == 5'd0) ? 32'h0 : d;
    endfunction

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; flush wins over everything.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (accept) state_d = FETCH2;
                FETCH2:  state_d = HOLD;
                HOLD:    if (lut_ready) state_d = accept ? FETCH2 : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs.
    always_comb begin
        req_ready = 1'b0;
        lut_valid = 1'b0;
        unique case (state_q)
            IDLE:    req_ready = !flush;
            HOLD:    begin
                req_ready = lut_ready && !flush;
                lut_valid = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    assign accept = req_valid && req_ready;

    // Register-file read addresses: rs1/rs2 on accept, rs3 in FETCH2.
    always_comb begin
        rf_ra_addr = 5'd0;
        rf_rb_addr = 5'd0;
        if (accept) begin
            rf_ra_addr = req_rs1;
            rf_rb_addr = req_rs2;
        end else if (state_q == FETCH2) begin
            rf_ra_addr = rs3_q;
        end
    end

    // Operand and destination registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            crs1_q <= 32'h0;
            crs2_q <= 32'h0;
            crs3_q <= 32'h0;
            rs3_q  <= 5'd0;
            rd_q   <= 5'd0;
        end else if (accept) begin
            crs1_q <= op_sel(req_rs1, rf_ra_data);
            crs2_q <= op_sel(req_rs2, rf_rb_data);
            rs3_q  <= req_rs3;
            rd_q   <= req_rd;
        end else if (state_q == FETCH2) begin
            crs3_q <= op_sel(rs3_q, rf_ra_data);
        end
    end

    assign lut_crs1 = crs1_q;
    assign lut_crs2 = crs2_q;
    assign lut_crs3 = crs3_q;
    assign lut_rd   = rd_q;

endmodule

// File: tb/tb_b_lut_opfetch.sv
// Bench for b_lut_opfetch: directed scenarios plus a randomized
// run against a transaction-level model with a register-file array.
module tb_b_lut_opfetch;

    logic        clock;
    logic        resetn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_rs1, req_rs2, req_rs3, req_rd;
    logic [4:0]  rf_ra_addr, rf_rb_addr;
    logic [31:0] rf_ra_data, rf_rb_data;
    logic [31:0] lut_crs1, lut_crs2, lut_crs3;
    logic [4:0]  lut_rd;
    logic        lut_valid;
    logic        lut_ready;

    logic [31:0] rf [0:31];
    logic [31:0] tog;

    int checks;
    int failures;

    b_lut_opfetch #(.X0_ZERO(1'b1)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rs3    (req_rs3),
        .req_rd     (req_rd),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .rf_ra_data (rf_ra_data),
        .rf_rb_data (rf_rb_data),
        .lut_crs1   (lut_crs1),
        .lut_crs2   (lut_crs2),
        .lut_crs3   (lut_crs3),
        .lut_rd     (lut_rd),
        .lut_valid  (lut_valid),
        .lut_ready  (lut_ready)
    );

    assign rf_ra_data = rf[rf_ra_addr] ^ tog;
    assign rf_rb_data = rf[rf_rb_addr] ^ tog;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] exp_op(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : rf[a];
    endfunction

    task automatic fill_rf();
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        lut_ready = 1'b1;
        flush     = 1'b0;
        tog       = 32'h0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        req_valid = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (lut_valid !== 1'b0 || lut_rd !== 5'd0) begin
            failures++;
            $display("FAIL reset_valid got=%b/%0d exp=0/0", lut_valid, lut_rd);
        end
        checks++;
        if ({lut_crs1, lut_crs2, lut_crs3} !== 96'h0) begin
            failures++;
            $display("FAIL reset_ops got=%h %h %h exp=0",
                     lut_crs1, lut_crs2, lut_crs3);
        end
        checks++;
        if (rf_ra_addr !== 5'd0 || rf_rb_addr !== 5'd0) begin
            failures++;
            $display("FAIL reset_addr got=%0d/%0d exp=0/0",
                     rf_ra_addr, rf_rb_addr);
        end
        @(negedge clock);
        resetn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_single();
        rf[1] = 32'h01234567;
        rf[2] = 32'h76543210;
        rf[3] = 32'hfedcba98;
        lut_ready = 1'b1;
        req_valid = 1'b1;
        req_rs1 = 5'd1; req_rs2 = 5'd2; req_rs3 = 5'd3; req_rd = 5'd4;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rf_ra_addr !== 5'd1 || rf_rb_addr !== 5'd2) begin
            failures++;
            $display("FAIL single_accept got=%b %0d %0d exp=1 1 2",
                     req_ready, rf_ra_addr, rf_rb_addr);
        end
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        checks++;
        if (lut_valid !== 1'b0 || req_ready !== 1'b0 ||
            rf_ra_addr !== 5'd3 || rf_rb_addr !== 5'd0) begin
            failures++;
            $display("FAIL single_fetch2 got=%b %b %0d %0d exp=0 0 3 0",
                     lut_valid, req_ready, rf_ra_addr, rf_rb_addr);
        end
        @(negedge clock);
        #1;
        checks++;
        if (lut_valid !== 1'b1 || lut_crs1 !== 32'h01234567 ||
            lut_crs2 !== 32'h76543210 || lut_crs3 !== 32'hfedcba98 ||
            lut_rd !== 5'd4) begin
            failures++;
            $display("FAIL single_out got=%b %h %h %h %0d exp=1 01234567 76543210 fedcba98 4",
                     lut_valid, lut_crs1, lut_crs2, lut_crs3, lut_rd);
        end
        @(negedge clock);
        #1;
        checks++;
        if (lut_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_done got=%b %b exp=0 1", lut_valid, req_ready);
        end
    endtask

    task automatic test_x0();
        rf[0] = 32'hffffffff;
        tog   = 32'h0;
        lut_ready = 1'b1;
        req_valid = 1'b1;
        req_rs1 = 5'd0; req_rs2 = 5'd0; req_rs3 = 5'd0; req_rd = 5'd9;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (lut_valid !== 1'b1 || {lut_crs1, lut_crs2, lut_crs3} !== 96'h0 ||
            lut_rd !== 5'd9) begin
            failures++;
            $display("FAIL x0_zero got=%b %h %h %h %0d exp=1 0 0 0 9",
                     lut_valid, lut_crs1, lut_crs2, lut_crs3, lut_rd);
        end
        @(negedge clock);
    endtask

    task automatic test_hold();
        logic [31:0] e1, e2, e3;
        fill_rf();
        lut_ready = 1'b0;
        req_valid = 1'b1;
        req_rs1 = 5'd5; req_rs2 = 5'd6; req_rs3 = 5'd7; req_rd = 5'd17;
        e1 = rf[5]; e2 = rf[6]; e3 = rf[7];
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            tog = $urandom;
            req_valid = 1'b1;
            req_rs1 = 5'($urandom_range(1, 31));
            #1;
            checks++;
            if (lut_valid !== 1'b1 || req_ready !== 1'b0 ||
                lut_crs1 !== e1 || lut_crs2 !== e2 || lut_crs3 !== e3 ||
                lut_rd !== 5'd17) begin
                failures++;
                $display("FAIL hold_stable c%0d got=%b %b %h %h %h %0d exp=1 0 %h %h %h 17",
                         i, lut_valid, req_ready, lut_crs1, lut_crs2, lut_crs3,
                         lut_rd, e1, e2, e3);
            end
            @(negedge clock);
        end
        tog = 32'h0;
        req_valid = 1'b0;
        lut_ready = 1'b1;
        #1;
        checks++;
        if (lut_valid !== 1'b1 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release got=%b %b exp=1 1", lut_valid, req_ready);
        end
        @(negedge clock);
        #1;
        checks++;
        if (lut_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_idle got=%b %b exp=0 1", lut_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] a [4];
        logic [4:0] b [4];
        fill_rf();
        for (int i = 0; i < 4; i++) begin
            a[i] = 5'($urandom_range(1, 31));
            b[i] = 5'($urandom_range(1, 31));
        end
        lut_ready = 1'b1;
        req_valid = 1'b1;
        req_rs1 = a[0]; req_rs2 = a[1]; req_rs3 = a[2]; req_rd = a[3];
        @(negedge clock);
        req_rs1 = b[0]; req_rs2 = b[1]; req_rs3 = b[2]; req_rd = b[3];
        #1;
        checks++;
        if (req_ready !== 1'b0 || lut_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_fetch got=%b %b exp=0 0", req_ready, lut_valid);
        end
        @(negedge clock);
        #1;
        checks++;
        if (lut_valid !== 1'b1 || req_ready !== 1'b1 ||
            rf_ra_addr !== b[0] || rf_rb_addr !== b[1] ||
            lut_crs1 !== rf[a[0]] || lut_crs2 !== rf[a[1]] ||
            lut_crs3 !== rf[a[2]] || lut_rd !== a[3]) begin
            failures++;
            $display("FAIL b2b_first got=%b %b %0d %0d %h %h %h %0d exp=1 1 %0d %0d %h %h %h %0d",
                     lut_valid, req_ready, rf_ra_addr, rf_rb_addr,
                     lut_crs1, lut_crs2, lut_crs3, lut_rd,
                     b[0], b[1], rf[a[0]], rf[a[1]], rf[a[2]], a[3]);
        end
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        checks++;
        if (lut_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap got=%b exp=0", lut_valid);
        end
        @(negedge clock);
        #1;
        checks++;
        if (lut_valid !== 1'b1 || lut_crs1 !== rf[b[0]] ||
            lut_crs2 !== rf[b[1]] || lut_crs3 !== rf[b[2]] ||
            lut_rd !== b[3]) begin
            failures++;
            $display("FAIL b2b_second got=%b %h %h %h %0d exp=1 %h %h %h %0d",
                     lut_valid, lut_crs1, lut_crs2, lut_crs3, lut_rd,
                     rf[b[0]], rf[b[1]], rf[b[2]], b[3]);
        end
        @(negedge clock);
    endtask

    task automatic test_flush();
        lut_ready = 1'b1;
        req_valid = 1'b1;
        req_rs1 = 5'd8; req_rs2 = 5'd9; req_rs3 = 5'd10; req_rd = 5'd11;
        @(negedge clock);
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=0", req_ready);
        end
        @(negedge clock);
        flush = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++;
        if (lut_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle got=%b %b exp=0 1", lut_valid, req_ready);
        end
        @(negedge clock);
        #1;
        checks++;
        if (lut_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_novalid got=%b exp=0", lut_valid);
        end
    endtask

    task automatic test_reset_mid();
        fill_rf();
        lut_ready = 1'b0;
        req_valid = 1'b1;
        req_rs1 = 5'd12; req_rs2 = 5'd13; req_rs3 = 5'd14; req_rd = 5'd15;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        #1;
        checks++;
        if (lut_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_hold got=%b exp=1", lut_valid);
        end
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (lut_valid !== 1'b0 || lut_rd !== 5'd0 ||
            {lut_crs1, lut_crs2, lut_crs3} !== 96'h0) begin
            failures++;
            $display("FAIL rstmid_async got=%b %h %h %h %0d exp=0 0 0 0 0",
                     lut_valid, lut_crs1, lut_crs2, lut_crs3, lut_rd);
        end
        @(negedge clock);
        resetn = 1'b1;
        lut_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (lut_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_nopulse c%0d got=%b exp=0", i, lut_valid);
            end
            @(negedge clock);
        end
    endtask

    typedef struct {
        int          rdy;
        logic [31:0] c1, c2, c3;
        logic [4:0]  rd, rs3;
    } txn_t;

    task automatic test_random();
        txn_t q[$];
        txn_t t;
        logic ev, er;
        fill_rf();
        tog = 32'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            lut_ready = ($urandom_range(0, 3) != 0);
            req_valid = $urandom_range(0, 1) == 1;
            req_rs1 = 5'($urandom_range(0, 31));
            req_rs2 = 5'($urandom_range(0, 31));
            req_rs3 = 5'($urandom_range(0, 31));
            req_rd  = 5'($urandom_range(0, 31));
            #1;
            ev = (q.size() > 0) && (q[0].rdy <= cyc);
            er = (q.size() == 0) || (ev && lut_ready);
            checks++;
            if (lut_valid !== ev || req_ready !== er) begin
                failures++;
                $display("FAIL rand_hs c%0d got=%b %b exp=%b %b",
                         cyc, lut_valid, req_ready, ev, er);
            end
            if (ev) begin
                checks++;
                if (lut_crs1 !== q[0].c1 || lut_crs2 !== q[0].c2 ||
                    lut_crs3 !== q[0].c3 || lut_rd !== q[0].rd) begin
                    failures++;
                    $display("FAIL rand_ops c%0d got=%h %h %h %0d exp=%h %h %h %0d",
                             cyc, lut_crs1, lut_crs2, lut_crs3, lut_rd,
                             q[0].c1, q[0].c2, q[0].c3, q[0].rd);
                end
            end
            if (q.size() > 0 && q[0].rdy == cyc + 1) begin
                checks++;
                if (rf_ra_addr !== q[0].rs3 || rf_rb_addr !== 5'd0) begin
                    failures++;
                    $display("FAIL rand_rs3 c%0d got=%0d %0d exp=%0d 0",
                             cyc, rf_ra_addr, rf_rb_addr, q[0].rs3);
                end
            end else if (req_valid && er) begin
                checks++;
                if (rf_ra_addr !== req_rs1 || rf_rb_addr !== req_rs2) begin
                    failures++;
                    $display("FAIL rand_addr c%0d got=%0d %0d exp=%0d %0d",
                             cyc, rf_ra_addr, rf_rb_addr, req_rs1, req_rs2);
                end
            end
            if (ev && lut_ready) void'(q.pop_front());
            if (req_valid && er) begin
                t.rdy = cyc + 2;
                t.c1  = exp_op(req_rs1);
                t.c2  = exp_op(req_rs2);
                t.c3  = exp_op(req_rs3);
                t.rd  = req_rd;
                t.rs3 = req_rs3;
                q.push_back(t);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        tog = 32'h0;
        flush = 1'b0;
        lut_ready = 1'b1;
        req_valid = 1'b0;
        req_rs1 = 5'd0; req_rs2 = 5'd0; req_rs3 = 5'd0; req_rd = 5'd0;
        resetn = 1'b0;
        fill_rf();
        @(negedge clock);
        test_reset();
        test_single();
        go_idle();
        test_x0();
        go_idle();
        test_hold();
        go_idle();
        test_back_to_back();
        go_idle();
        test_flush();
        go_idle();
        test_reset_mid();
        go_idle();
        test_random();
        go_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
